// File: rtl/keycode_arb_pkg.sv
// keycode_arb_pkg: shared state encoding, default widths and requester ids for the keycode bus arbiter
package keycode_arb_pkg;
    typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 2;
    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_INJ = 1'b1;
endpackage

// File: rtl/keycode_rr_pick.sv
// keycode_rr_pick: combinational two-way picker, round-robin or fixed priority to requester 0
// ports: req[1:0] requests, last_grant previous winner, rr_enable mode select; valid any request, winner chosen id
module keycode_rr_pick
    import keycode_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       rr_enable,
    output logic       valid,
    output logic       winner
);
    always_comb begin
        valid  = |req;
        winner = (req == 2'b11) ? (rr_enable ? ~last_grant : REQ_CPU) : (req[1] ? REQ_INJ : REQ_CPU);
    end
endmodule

// File: rtl/keycode_bus_arbiter.sv
// keycode_bus_arbiter: serialises two Avalon-MM requesters onto the keycode PIO slave
// ports: clk/reset (async, active high); m0_*/m1_* requester req/write/addr/wdata in, ack/rdata out;
//        s_chipselect/s_address/s_write_n/s_writedata to the slave, s_readdata from it; busy when not IDLE
module keycode_bus_arbiter
    import keycode_arb_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int RR_ENABLE = 1
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_write,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_write,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              s_chipselect,
    output logic [ADDR_W-1:0] s_address,
    output logic              s_write_n,
    output logic [DATA_W-1:0] s_writedata,
    input  logic [DATA_W-1:0] s_readdata,
    output logic              busy
);
    state_t state, state_nx;
    logic last_grant, gnt_id, cmd_write, pick_valid, pick_winner;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    keycode_rr_pick u_pick (
        .req        ({m1_req, m0_req}),
        .last_grant (last_grant),
        .rr_enable  (RR_ENABLE != 0),
        .valid      (pick_valid),
        .winner     (pick_winner)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Slave-side outputs decode straight from registered state so an async reset clears them at once.
    always_comb begin
        state_nx     = (state == IDLE) ? (pick_valid ? ACCESS : IDLE) : (state == ACCESS) ? ACK : IDLE;
        busy         = state != IDLE;
        s_chipselect = state == ACCESS;
        s_write_n    = !(state == ACCESS && cmd_write);
        s_address    = cmd_addr;
        s_writedata  = cmd_wdata;
        m0_ack       = state == ACK && gnt_id == REQ_CPU;
        m1_ack       = state == ACK && gnt_id == REQ_INJ;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= REQ_INJ;
            gnt_id     <= REQ_CPU;
            cmd_write  <= 1'b0;
            cmd_addr   <= '0;
            cmd_wdata  <= '0;
            m0_rdata   <= '0;
            m1_rdata   <= '0;
        end else begin
            if (state == IDLE && pick_valid) begin
                last_grant <= pick_winner;
                gnt_id     <= pick_winner;
                cmd_write  <= pick_winner ? m1_write : m0_write;
                cmd_addr   <= pick_winner ? m1_addr : m0_addr;
                cmd_wdata  <= pick_winner ? m1_wdata : m0_wdata;
            end
            if (state == ACCESS && !cmd_write) begin
                if (gnt_id == REQ_INJ) m1_rdata <= s_readdata;
                else                   m0_rdata <= s_readdata;
            end
        end
    end
endmodule

// File: tb/tb_keycode_bus_arbiter.sv
// tb_keycode_bus_arbiter: scoreboard bench with a transaction-level reference model for the keycode bus arbiter
module tb_keycode_bus_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [1:0] req = '0, wr = '0;
    logic [1:0] addr [2];
    logic [31:0] wd [2];
    wire [1:0] ack;
    wire [31:0] rd0, rd1, swd;
    wire [1:0] sa;
    wire cs, wn, bsy;
    logic [31:0] kc = '0;
    wire [31:0] srd = (sa == 2'd0) ? kc : 32'h0;

    logic [1:0] freq = '0;
    wire [1:0] fack, fsa;
    wire [31:0] frd0, frd1, fswd;
    wire fcs, fwn, fbsy;
    wire [31:0] fsrd = 32'h1234_5678;

    int total = 0, bad = 0;
    logic [32:0] ack_q [$];
    logic [34:0] bus_q [$];
    int m_cnt = 0;
    bit m_last = 1'b1;
    logic [31:0] m_rd [2];
    logic [31:0] m_kc = '0;

    always #5 clk = ~clk;

    keycode_bus_arbiter #(.DATA_W(32), .ADDR_W(2), .RR_ENABLE(1)) dut (
        .clk(clk), .reset(reset),
        .m0_req(req[0]), .m0_write(wr[0]), .m0_addr(addr[0]), .m0_wdata(wd[0]), .m0_ack(ack[0]), .m0_rdata(rd0),
        .m1_req(req[1]), .m1_write(wr[1]), .m1_addr(addr[1]), .m1_wdata(wd[1]), .m1_ack(ack[1]), .m1_rdata(rd1),
        .s_chipselect(cs), .s_address(sa), .s_write_n(wn), .s_writedata(swd), .s_readdata(srd), .busy(bsy)
    );

    keycode_bus_arbiter #(.DATA_W(32), .ADDR_W(2), .RR_ENABLE(0)) dut_fp (
        .clk(clk), .reset(reset),
        .m0_req(freq[0]), .m0_write(1'b0), .m0_addr(2'd0), .m0_wdata(32'h0), .m0_ack(fack[0]), .m0_rdata(frd0),
        .m1_req(freq[1]), .m1_write(1'b0), .m1_addr(2'd0), .m1_wdata(32'h0), .m1_ack(fack[1]), .m1_rdata(frd1),
        .s_chipselect(fcs), .s_address(fsa), .s_write_n(fwn), .s_writedata(fswd), .s_readdata(fsrd), .busy(fbsy)
    );

    always @(posedge clk) if (cs && !wn && sa == 2'd0) kc <= swd;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one transfer occupies three cycles; the winner follows the arbitration rules.
    initial begin
        bit w;
        logic [31:0] e;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_cnt = 0; m_last = 1'b1; m_rd[0] = '0; m_rd[1] = '0;
                ack_q.delete(); bus_q.delete();
            end else if (m_cnt > 0) begin
                m_cnt--;
            end else if (req != 2'b00) begin
                w = (req == 2'b11) ? !m_last : req[1];
                e = wr[w] ? m_rd[w] : (addr[w] == 2'd0 ? m_kc : 32'h0);
                m_rd[w] = e;
                if (wr[w] && addr[w] == 2'd0) m_kc = wd[w];
                ack_q.push_back({w, e});
                bus_q.push_back({wr[w], addr[w], wd[w]});
                m_last = w;
                m_cnt = 2;
            end
        end
    end

    initial begin
        logic [32:0] e;
        logic [34:0] b;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (ack != 2'b00) begin
                    if (ack_q.size() == 0) chk("spurious_ack", ack, 2'b00);
                    else begin
                        e = ack_q.pop_front();
                        chk("ack_id", ack, e[32] ? 2'b10 : 2'b01);
                        chk("ack_rdata", e[32] ? rd1 : rd0, e[31:0]);
                    end
                end
                if (cs) begin
                    if (bus_q.size() == 0) chk("spurious_strobe", cs, 1'b0);
                    else begin
                        b = bus_q.pop_front();
                        chk("slave_cmd", {!wn, sa, swd}, b);
                    end
                end
            end
        end
    end

    task automatic wait_ack(input int k, input int lim, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!ack[k] && cyc < lim);
        if (!ack[k]) chk($sformatf("ack_timeout_m%0d", k), 0, 1);
    endtask

    task automatic xfer(input int k, input bit w, input logic [1:0] a, input logic [31:0] d);
        int c;
        wr[k] = w; addr[k] = a; wd[k] = d; req[k] = 1'b1;
        wait_ack(k, 20, c);
        req[k] = 1'b0;
    endtask

    task automatic agent(input int k, input int n);
        int c;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            wr[k] = 1'($urandom_range(0, 1));
            addr[k] = 2'($urandom_range(0, 3));
            wd[k] = $urandom;
            req[k] = 1'b1;
            wait_ack(k, 30, c);
            req[k] = 1'b0;
        end
    endtask

    initial begin
        int c0, c1, f0, f1, fst, n;
        addr[0] = '0; addr[1] = '0; wd[0] = '0; wd[1] = '0;
        repeat (3) @(negedge clk);
        chk("reset_ctrl", {cs, wn, bsy, ack, sa}, {1'b0, 1'b1, 1'b0, 2'b00, 2'b00});
        chk("reset_data", {rd0, rd1}, 64'h0);
        chk("reset_wdata", swd, 32'h0);
        reset = 1'b0;

        wr[0] = 1'b1; addr[0] = 2'd0; wd[0] = 32'h0000_1A04; req[0] = 1'b1;
        @(negedge clk);
        chk("wr_strobe_c1", {cs, wn, ack}, {1'b1, 1'b0, 2'b00});
        @(negedge clk);
        chk("wr_ack_c2", {cs, ack}, {1'b0, 2'b01});
        req[0] = 1'b0;
        xfer(1, 1'b0, 2'd0, 32'h0);
        chk("m1_read_back", rd1, 32'h0000_1A04);

        @(negedge clk);
        wr = 2'b00; addr[0] = 2'd0; addr[1] = 2'd0; req = 2'b11; c0 = 0; c1 = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (ack[0]) begin c0 = i; req[0] = 1'b0; end
            if (ack[1]) begin c1 = i; req[1] = 1'b0; end
        end
        chk("rr_m0_latency", c0, 2);
        chk("rr_m1_latency", c1, 5);
        req = 2'b11;
        for (int t = 0; t < 4; t++) begin
            n = 0;
            do begin @(negedge clk); n++; end while (ack == 2'b00 && n < 10);
            chk($sformatf("rr_alternate_%0d", t), ack, (t % 2) ? 2'b10 : 2'b01);
            if (ack[0]) addr[0] = 2'($urandom_range(0, 3));
            if (ack[1]) addr[1] = 2'($urandom_range(0, 3));
        end
        req = 2'b00;

        freq = 2'b11; f0 = 0; f1 = 0; fst = 0;
        for (int i = 0; i < 60 && f0 < 10; i++) begin
            @(negedge clk);
            if (fack[0]) f0++;
            if (fack[1]) f1++;
            if (fcs) fst++;
        end
        freq = 2'b00;
        chk("fp_m0_acks", f0, 10);
        chk("fp_m1_starved", f1, 0);
        chk("fp_strobes", fst, 10);
        chk("fp_rdata", {frd0, frd1}, {32'h1234_5678, 32'h0});
        repeat (3) @(negedge clk);
        chk("fp_idle", {fbsy, fcs, fwn, fsa, fswd}, {1'b0, 1'b0, 1'b1, 2'b00, 32'h0});

        xfer(1, 1'b1, 2'd0, 32'hDEAD_BEEF);
        xfer(1, 1'b0, 2'd0, 32'h0);
        chk("m1_deadbeef", rd1, 32'hDEAD_BEEF);
        xfer(0, 1'b0, 2'd2, 32'h0);
        chk("oob_read_zero", rd0, 32'h0);
        chk("other_rdata_kept", rd1, 32'hDEAD_BEEF);

        @(negedge clk);
        wr[1] = 1'b1; addr[1] = 2'd0; wd[1] = 32'h29; req[1] = 1'b1;
        @(negedge clk);
        chk("pre_reset_strobe", {cs, wn}, {1'b1, 1'b0});
        #2 reset = 1'b1;
        #1;
        chk("midreset_ctrl", {cs, wn, bsy, ack, sa}, {1'b0, 1'b1, 1'b0, 2'b00, 2'b00});
        chk("midreset_rdata", {rd0, rd1}, 64'h0);
        chk("midreset_wdata", swd, 32'h0);
        req = 2'b00;
        @(negedge clk);
        @(negedge clk);
        chk("reset_no_ack", ack, 2'b00);
        reset = 1'b0;
        wr = 2'b00; addr[0] = 2'd1; addr[1] = 2'd1; req = 2'b11;
        n = 0;
        do begin @(negedge clk); n++; end while (ack == 2'b00 && n < 10);
        chk("post_reset_first", ack, 2'b01);
        req[0] = 1'b0;
        wait_ack(1, 10, n);
        req[1] = 1'b0;

        @(negedge clk);
        wr[0] = 1'b1; addr[0] = 2'd0; wd[0] = 32'h11; req[0] = 1'b1;
        @(negedge clk);
        wd[0] = 32'h22;
        chk("latched_wdata", {cs, swd}, {1'b1, 32'h11});
        wait_ack(0, 10, n);
        req[0] = 1'b0;
        xfer(1, 1'b0, 2'd0, 32'h0);
        chk("latched_readback", rd1, 32'h11);

        fork
            agent(0, 30);
            agent(1, 30);
        join
        repeat (5) @(negedge clk);
        chk("scoreboard_drained", {32'(ack_q.size()), 32'(bus_q.size())}, 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
